// File: rtl/gin_multicast_receiver.sv
// Tag-addressed multicast of one payload to a ROWS x COLS PE array using loadable Y/X IDs.
// Latency 1 from accept to pe_valid/no_match; in_ready stays low until every addressed PE has accepted.
module gin_multicast_receiver #(
   parameter int DATA_W = 32,
   parameter int ROWS   = 6,
   parameter int COLS   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   set_id,
   input  logic                   cfg_valid,
   input  logic [4:0]             cfg_id,
   output logic                   cfg_done,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   input  logic [2:0]             in_tag_y,
   input  logic [4:0]             in_tag_x,
   output logic [ROWS*COLS-1:0]   pe_valid,
   input  logic [ROWS*COLS-1:0]   pe_ready,
   output logic [DATA_W-1:0]      pe_data,
   output logic                   no_match
);

   localparam int NPE   = ROWS * COLS;
   localparam int NBEAT = ROWS + NPE;
   localparam int BW    = $clog2(NBEAT + 1);

   typedef enum logic [1:0] {ST_CFG, ST_READY, ST_DELIVER} state_t;

   state_t            state, state_nxt;
   logic [BW-1:0]     beat;
   logic [2:0]        yid [ROWS];
   logic [4:0]        xid [NPE];
   logic [NPE-1:0]    pending;
   logic [NPE-1:0]    match;
   logic [NPE-1:0]    remaining;
   logic              accept;
   logic              hit;
   logic              last_beat;
   logic              cfg_wr;

   // YID 7 / XID 31 are reserved as "disabled"; a tag carrying them never matches.
   for (genvar g = 0; g < NPE; g++) begin : g_match
      assign match[g] = (yid[g / COLS] == in_tag_y) && (xid[g] == in_tag_x) &&
                        (in_tag_y != 3'd7) && (in_tag_x != 5'd31);
   end

   assign hit       = |match;
   assign accept    = in_valid && (state == ST_READY);
   assign last_beat = (beat == BW'(NBEAT - 1));
   assign cfg_wr    = (state == ST_CFG) && cfg_valid && !set_id;
   assign remaining = pending & ~pe_ready;
   assign pe_valid  = pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_CFG;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (set_id) begin
         state_nxt = ST_CFG;
      end else begin
         case (state)
            ST_CFG:     if (cfg_valid && last_beat) state_nxt = ST_READY;
            ST_READY:   if (accept && hit)          state_nxt = ST_DELIVER;
            ST_DELIVER: if (remaining == '0)        state_nxt = ST_READY;
            default:                                state_nxt = ST_CFG;
         endcase
      end
   end

   always_comb begin
      in_ready = (state == ST_READY);
      cfg_done = (state != ST_CFG);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat <= '0;
         for (int i = 0; i < ROWS; i++) yid[i] <= 3'd7;
         for (int i = 0; i < NPE; i++)  xid[i] <= 5'd31;
      end else if (set_id) begin
         beat <= '0;
      end else if (cfg_wr) begin
         beat <= beat + 1'b1;
         for (int i = 0; i < ROWS; i++) begin
            if (beat == BW'(i)) yid[i] <= cfg_id[2:0];
         end
         for (int i = 0; i < NPE; i++) begin
            if (beat == BW'(ROWS + i)) xid[i] <= cfg_id;
         end
      end
   end

   // A packet that hits nobody is consumed here: only no_match reports it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         pe_data  <= '0;
         no_match <= 1'b0;
      end else begin
         no_match <= 1'b0;
         if (set_id) begin
            pending <= '0;
         end else if (accept) begin
            if (hit) begin
               pending <= match;
               pe_data <= in_data;
            end else begin
               no_match <= 1'b1;
            end
         end else if (state == ST_DELIVER) begin
            pending <= remaining;
         end
      end
   end

endmodule

// File: tb/tb_gin_multicast_receiver.sv
// Bench for gin_multicast_receiver: table of packets plus hand-written multi-cycle sequences.
module tb_gin_multicast_receiver;
   localparam int DW = 32;
   localparam int R  = 6;
   localparam int C  = 8;
   localparam int N  = R * C;
   localparam int NB = R + N;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          set_id, cfg_valid, cfg_done;
   logic [4:0]    cfg_id;
   logic          in_valid, in_ready;
   logic [DW-1:0] in_data;
   logic [2:0]    in_tag_y;
   logic [4:0]    in_tag_x;
   logic [N-1:0]  pe_valid, pe_ready;
   logic [DW-1:0] pe_data;
   logic          no_match;

   always #5 clk = ~clk;

   gin_multicast_receiver #(.DATA_W(DW), .ROWS(R), .COLS(C)) dut (
      .clk(clk), .rst_n(rst_n), .set_id(set_id), .cfg_valid(cfg_valid), .cfg_id(cfg_id),
      .cfg_done(cfg_done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_tag_y(in_tag_y), .in_tag_x(in_tag_x), .pe_valid(pe_valid), .pe_ready(pe_ready),
      .pe_data(pe_data), .no_match(no_match)
   );

   typedef struct {
      logic [2:0]    ty;
      logic [4:0]    tx;
      logic [DW-1:0] d;
      logic [N-1:0]  m;
      logic          nm;
   } vec_t;

   typedef struct {
      logic [N-1:0]  m;
      logic          nm;
      logic [DW-1:0] d;
   } exp_t;

   exp_t          sb[$];
   vec_t          vt[8];
   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] last_data;
   logic [2:0]    ycfg[R];
   logic [4:0]    xcfg[N];

   function automatic logic [N-1:0] bm(input int a, input int b, input int c);
      logic [N-1:0] v;
      v = '0;
      v[a] = 1'b1;
      v[b] = 1'b1;
      v[c] = 1'b1;
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_std(input logic row0_off);
      for (int r = 0; r < R; r++) ycfg[r] = (r < 3) ? 3'd0 : 3'd1;
      for (int i = 0; i < N; i++) xcfg[i] = (row0_off && i < C) ? 5'd31 : 5'(i % C);
   endtask

   task automatic load(input int nb);
      for (int b = 0; b < nb; b++) begin
         cfg_valid = 1'b1;
         cfg_id    = (b < R) ? {2'b00, ycfg[b]} : xcfg[b - R];
         tick();
         if (nb == NB && b == NB - 2) check("cfg_done_before_last", 64'(cfg_done), 64'd0);
         if (nb == NB && b == NB - 1) begin
            check("cfg_done_after_last", 64'(cfg_done), 64'd1);
            check("in_ready_after_cfg", 64'(in_ready), 64'd1);
         end
      end
      cfg_valid = 1'b0;
      cfg_id    = '0;
   endtask

   task automatic pulse_set_id();
      set_id = 1'b1;
      tick();
      set_id = 1'b0;
      check("cfg_done_after_set_id", 64'(cfg_done), 64'd0);
   endtask

   // Pops the expectation pushed by send() once the DUT has had its one cycle to respond.
   task automatic observe();
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_empty: actual=0 entries required=1");
      end else begin
         e = sb.pop_front();
         check("pe_valid", 64'(pe_valid), 64'(e.m));
         check("no_match", 64'(no_match), 64'(e.nm));
         check("pe_data", 64'(pe_data), 64'(e.d));
         check("in_ready_after_accept", 64'(in_ready), 64'(e.m == '0));
         if (e.m != '0) begin
            pe_ready = '1;
            tick();
            pe_ready = '0;
            check("pe_valid_drained", 64'(pe_valid), 64'd0);
            check("in_ready_after_drain", 64'(in_ready), 64'd1);
         end else begin
            tick();
            check("no_match_one_cycle", 64'(no_match), 64'd0);
            check("pe_valid_idle", 64'(pe_valid), 64'd0);
         end
      end
   endtask

   task automatic send(input logic [2:0] ty, input logic [4:0] tx, input logic [DW-1:0] d,
                       input logic [N-1:0] m, input logic nm);
      exp_t e;
      int   w;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      check("in_ready_before_send", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_tag_y = ty;
      in_tag_x = tx;
      in_data  = d;
      if (m != '0) last_data = d;
      e.m  = m;
      e.nm = nm;
      e.d  = last_data;
      sb.push_back(e);
      tick();
      in_valid = 1'b0;
      observe();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{ty: 3'd0, tx: 5'd0,  d: 32'h1111_1111, m: bm(0, 8, 16),   nm: 1'b0};
      vt[1] = '{ty: 3'd5, tx: 5'd3,  d: 32'h2222_2222, m: '0,             nm: 1'b1};
      vt[2] = '{ty: 3'd0, tx: 5'd7,  d: 32'h3333_3333, m: bm(7, 15, 23),  nm: 1'b0};
      vt[3] = '{ty: 3'd1, tx: 5'd31, d: 32'h4444_4444, m: '0,             nm: 1'b1};
      vt[4] = '{ty: 3'd7, tx: 5'd0,  d: 32'h5555_5555, m: '0,             nm: 1'b1};
      vt[5] = '{ty: 3'd1, tx: 5'd0,  d: 32'h6666_6666, m: bm(24, 32, 40), nm: 1'b0};
      vt[6] = '{ty: 3'd0, tx: 5'd8,  d: 32'h7777_7777, m: '0,             nm: 1'b1};
      vt[7] = '{ty: 3'd1, tx: 5'd5,  d: 32'h8888_8888, m: bm(29, 37, 45), nm: 1'b0};

      rst_n = 1'b1; set_id = 1'b0; cfg_valid = 1'b0; cfg_id = '0;
      in_valid = 1'b0; in_data = '0; in_tag_y = '0; in_tag_x = '0; pe_ready = '0;
      last_data = '0;
      #3 rst_n = 1'b0;
      #1;
      check("rst_cfg_done", 64'(cfg_done), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_pe_valid", 64'(pe_valid), 64'd0);
      check("rst_pe_data", 64'(pe_data), 64'd0);
      check("rst_no_match", 64'(no_match), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      set_std(1'b0);
      load(NB);

      // Staggered accept: bit 27 first, then 35 and 43 together two cycles later.
      in_valid = 1'b1; in_tag_y = 3'd1; in_tag_x = 5'd3; in_data = 32'hA5A5_A5A5;
      tick();
      in_tag_y = 3'd0; in_tag_x = 5'd0; in_data = 32'hDEAD_BEEF;
      check("stag_pe_valid_c1", 64'(pe_valid), 64'(bm(27, 35, 43)));
      check("stag_pe_data_c1", 64'(pe_data), 64'hA5A5_A5A5);
      check("stag_in_ready_c1", 64'(in_ready), 64'd0);
      pe_ready = bm(27, 0, 0);
      tick();
      pe_ready = '0;
      check("stag_pe_valid_c2", 64'(pe_valid), 64'(bm(35, 43, 43)));
      tick();
      in_valid = 1'b0;
      check("stag_pe_valid_c3", 64'(pe_valid), 64'(bm(35, 43, 43)));
      check("stag_in_ready_c3", 64'(in_ready), 64'd0);
      check("stag_pe_data_c3", 64'(pe_data), 64'hA5A5_A5A5);
      pe_ready = bm(35, 43, 43);
      tick();
      pe_ready = '0;
      check("stag_pe_valid_c4", 64'(pe_valid), 64'd0);
      check("stag_in_ready_c4", 64'(in_ready), 64'd1);
      check("stag_no_match_c4", 64'(no_match), 64'd0);
      last_data = 32'hA5A5_A5A5;

      for (int i = 0; i < 8; i++) send(vt[i].ty, vt[i].tx, vt[i].d, vt[i].m, vt[i].nm);

      // Row 0 disabled via XID 31.
      pulse_set_id();
      set_std(1'b1);
      load(NB);
      send(3'd0, 5'd31, 32'h9999_9999, '0, 1'b1);
      send(3'd0, 5'd0,  32'hAAAA_0001, bm(8, 16, 16), 1'b0);
      send(3'd0, 5'd5,  32'hAAAA_0002, bm(13, 21, 21), 1'b0);

      // set_id while deliveries are pending, with a simultaneous cfg beat.
      in_valid = 1'b1; in_tag_y = 3'd0; in_tag_x = 5'd0; in_data = 32'h1234_5678;
      tick();
      in_valid = 1'b0;
      check("abort_pe_valid_pending", 64'(pe_valid), 64'(bm(8, 16, 16)));
      set_id = 1'b1; cfg_valid = 1'b1; cfg_id = 5'd5;
      tick();
      set_id = 1'b0; cfg_valid = 1'b0;
      check("abort_pe_valid", 64'(pe_valid), 64'd0);
      check("abort_cfg_done", 64'(cfg_done), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd0);
      last_data = 32'h1234_5678;
      set_std(1'b0);
      load(NB);
      send(3'd0, 5'd0, 32'hBBBB_0001, bm(0, 8, 16), 1'b0);

      // set_id mid-config with a beat in the same cycle: that beat must not count.
      pulse_set_id();
      load(10);
      set_id = 1'b1; cfg_valid = 1'b1; cfg_id = 5'd3;
      tick();
      set_id = 1'b0; cfg_valid = 1'b0;
      load(NB);
      send(3'd1, 5'd2, 32'hCCCC_0001, bm(26, 34, 42), 1'b0);

      // Asynchronous reset mid-config.
      pulse_set_id();
      load(20);
      @(negedge clk) rst_n = 1'b0;
      #1;
      check("arst_cfg_done", 64'(cfg_done), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd0);
      check("arst_pe_valid", 64'(pe_valid), 64'd0);
      check("arst_pe_data", 64'(pe_data), 64'd0);
      check("arst_no_match", 64'(no_match), 64'd0);
      last_data = '0;
      @(negedge clk) rst_n = 1'b1;
      tick();
      check("arst_still_cfg", 64'(cfg_done), 64'd0);
      load(NB);
      send(3'd1, 5'd3, 32'hA5A5_A5A5, bm(27, 35, 43), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
